division_arbiter: RTL and testbench
===================================

Name: division_arbiter

Overview:
- Shares one pipelined fixed-point Division instance (Q.15 result, fixed latency LAT) among nReq requesters of the pseudoinverse datapath.
- Arbitrates requests round-robin and issues at most one operation per cycle.
- Tags each in-flight operation and returns every result with its requester ID.
- Short-circuits divide-by-zero with a saturated result.

Parameters:
- nBits, 32, operand/result width
- nReq, 4, number of requesters (2..8)
- LAT, 36, divider latency in cycles from div_a/div_b valid to div_res valid
- idW, 2, requester ID width, equal to clog2(nReq)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req  in  nReq  per-requester request; held with operands until ack
- a_bus  in  nReq*nBits  dividends; requester i in slice [i*nBits +: nBits]
- b_bus  in  nReq*nBits  divisors, same packing
- ack  out  nReq  one-hot grant, combinational, same cycle as accepted req
- div_a  out  nBits  registered dividend to divider
- div_b  out  nBits  registered divisor to divider
- div_ce  out  1  divider clock enable
- div_res  in  nBits  divider result
- res  out  nBits  registered result
- res_id  out  idW  requester ID of res
- res_valid  out  1  one-cycle pulse, res/res_id valid
- res_dz  out  1  result came from divide-by-zero path
- inflight  out  clog2(LAT+2)  operations issued, not yet returned
- busy  out  1  inflight != 0

Behaviour:
- Reset, when rst_n is low at an edge: ptr=0, tag pipeline cleared, div_a=div_b=0, res=0, res_id=0, res_valid=0, res_dz=0, inflight=0, div_ce=0. ack is forced to 0 while rst_n is low.
- div_ce=1 on every cycle after reset. The divider never stalls, and the tag pipeline advances every cycle.
- Arbitration: each cycle, grant the first requester with req=1, searching from ptr upward with wrap at nReq-1 -> 0. ack[g]=1 only for that requester. No grant when req is all zero.
- Pointer update: on a grant, ptr <= g+1 (mod nReq). With no grant, ptr holds.
- Requester handshake: after seeing ack, the requester drops req or presents new operands on the next cycle. A held req with ack=0 keeps its operands stable.
- Issue at edge E, when a grant exists: div_a <= a of g; div_b <= b of g. Tag stage 0 <= {valid=1, id=g, dz=(b==0), sign=a[nBits-1], az=(a==0)}.
- No grant at an edge: stage 0 valid <= 0, and div_a/div_b hold.
- Tag pipeline: LAT+1 stages, a shift register. Stage LAT aligns with div_res.
- Return at edge E+LAT+1, where E is the issue edge: res_valid=1 and res_id=id.
  - If dz=0: res=div_res, res_dz=0.
  - If dz=1: res_dz=1, and res is 0 when az; 0x7FFFFFFF (nBits-wide max positive) when sign=0 and !az; 0x80000000 (min negative) when sign=1.
- Latency: LAT+1 cycles from ack to res_valid, constant. Throughput is 1 op/cycle, and results return in issue order.
- inflight: +1 on issue, -1 on return, unchanged when both happen in the same cycle. Maximum is LAT+1, and it never overflows.
- Results have no backpressure. Each requester must accept res on res_valid with res_id matching its index.
- Reset mid-operation: all in-flight operations are discarded. No res_valid is generated for them after reset releases.
- Single requester: it may be granted every cycle.
- All requesting: strict rotation 0,1,2,3,0,... when starting from ptr=0.

Test Plan:
Bench divider model: registered LAT-deep pipe of (a<<15)/b, with LAT=4 and nReq=4.
- Single op: req[2]=1, a=6, b=3 -> ack=0100 in the same cycle; 5 cycles later res_valid=1, res=0x00010000, res_id=2, res_dz=0; inflight goes 1 then back to 0.
- All four requesters hold req for 8 cycles, each with a=id+1, b=1 -> acks rotate 0,1,2,3,0,1,2,3 on consecutive cycles; results return in the same ID order, one per cycle, starting 5 cycles after the first ack; inflight peaks at 5.
- Divide-by-zero: requester 1 issues a=5,b=0, then a=-5,b=0, then a=0,b=0 -> three results 0x7FFFFFFF, 0x80000000, 0x00000000, all with res_dz=1 and res_id=1.
- Fairness: req[0] held continuously and req[3] asserted at cycle 2 -> req[3] is granted within 4 cycles of assertion; req[0] is never granted twice in a row while req[3] is pending.
- Reset mid-flight: issue 3 ops, then pulse rst_n low 1 cycle, 2 cycles after the last issue -> no res_valid at all after reset; inflight=0, ptr=0; the next req[1] gets ack and returns normally.
- Idle/hold: req=0 for 10 cycles -> ack=0, res_valid=0, busy=0, div_a/div_b unchanged, div_ce=1.

Source files
------------

// File: rtl/division_arbiter.sv
// division_arbiter: round-robin sharing of one fixed-latency pipelined divider among nReq requesters,
// with ID tagging and a saturated divide-by-zero bypass.
module division_arbiter #(
    parameter int nBits = 32,
    parameter int nReq  = 4,
    parameter int LAT   = 36,
    parameter int idW   = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [nReq-1:0]           req_i,
    input  logic [nReq*nBits-1:0]     a_bus_i,
    input  logic [nReq*nBits-1:0]     b_bus_i,
    output logic [nReq-1:0]           ack_o,
    output logic [nBits-1:0]          div_a_o,
    output logic [nBits-1:0]          div_b_o,
    output logic                      div_ce_o,
    input  logic [nBits-1:0]          div_res_i,
    output logic [nBits-1:0]          res_o,
    output logic [idW-1:0]            res_id_o,
    output logic                      res_valid_o,
    output logic                      res_dz_o,
    output logic [$clog2(LAT+2)-1:0]  inflight_o,
    output logic                      busy_o
);
    localparam int IW = $clog2(LAT + 2);
    typedef struct packed {
        logic           v;
        logic [idW-1:0] id;
        logic           dz;
        logic           sg;
        logic           az;
    } tag_t;
    tag_t            tag_q [LAT+1];
    tag_t            tag_d;
    tag_t            last;
    logic [idW-1:0]  ptr_q, ptr_d, gnt_id, res_id_q;
    logic            gnt_v, ret, ce_q, res_valid_q, res_dz_q;
    logic [nBits-1:0] a_g, b_g, sat, res_d, div_a_q, div_b_q, res_q;
    logic [IW-1:0]   infl_q, infl_d;
    always_comb begin
        gnt_v  = 1'b0;
        gnt_id = '0;
        for (int k = nReq - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_q) + k) % nReq]) begin
                gnt_v  = 1'b1;
                gnt_id = idW'((int'(ptr_q) + k) % nReq);
            end
        end
    end
    assign ack_o  = (rst_ni && gnt_v) ? nReq'(1) << gnt_id : '0;
    assign a_g    = a_bus_i[gnt_id*nBits +: nBits];
    assign b_g    = b_bus_i[gnt_id*nBits +: nBits];
    assign ptr_d  = (gnt_id == idW'(nReq - 1)) ? '0 : gnt_id + 1'b1;
    assign tag_d  = {gnt_v, gnt_id, b_g == '0, a_g[nBits-1], a_g == '0};
    // the last tag stage lines up with the divider output
    assign last   = tag_q[LAT];
    assign ret    = last.v;
    assign sat    = last.az ? '0 : last.sg ? {1'b1, {(nBits-1){1'b0}}} : {1'b0, {(nBits-1){1'b1}}};
    assign res_d  = last.dz ? sat : div_res_i;
    assign infl_d = (gnt_v && !ret) ? infl_q + 1'b1 : (ret && !gnt_v) ? infl_q - 1'b1 : infl_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            tag_q       <= '{default: '0};
            div_a_q     <= '0;
            div_b_q     <= '0;
            ce_q        <= 1'b0;
            res_q       <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            res_dz_q    <= 1'b0;
            infl_q      <= '0;
        end else begin
            ce_q     <= 1'b1;
            tag_q[0] <= tag_d;
            for (int i = 1; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
            if (gnt_v) begin
                ptr_q   <= ptr_d;
                div_a_q <= a_g;
                div_b_q <= b_g;
            end
            res_valid_q <= ret;
            if (ret) begin
                res_q    <= res_d;
                res_id_q <= last.id;
                res_dz_q <= last.dz;
            end
            infl_q <= infl_d;
        end
    end
    assign div_a_o     = div_a_q;
    assign div_b_o     = div_b_q;
    assign div_ce_o    = ce_q;
    assign res_o       = res_q;
    assign res_id_o    = res_id_q;
    assign res_valid_o = res_valid_q;
    assign res_dz_o    = res_dz_q;
    assign inflight_o  = infl_q;
    assign busy_o      = infl_q != '0;
endmodule

// File: tb/tb_division_arbiter.sv
// tb_division_arbiter: scoreboard bench for division_arbiter with a 4-deep Q.15 divider model.
module tb_division_arbiter;
    localparam int NB = 32;
    localparam int NR = 4;
    localparam int LT = 4;
    localparam int IW = 2;
    typedef struct {
        logic [IW-1:0] id;
        logic [NB-1:0] r;
        logic          dz;
        int            cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR*NB-1:0] a_bus = '0;
    logic [NR*NB-1:0] b_bus = '0;
    logic [NR-1:0] ack;
    logic [NB-1:0] div_a, div_b, div_res, res;
    logic div_ce, res_valid, res_dz, busy;
    logic [IW-1:0] res_id;
    logic [$clog2(LT+2)-1:0] inflight;
    logic [NB-1:0] dp [LT];
    exp_t sb [$];
    exp_t e;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int g;
    division_arbiter #(.nBits(NB), .nReq(NR), .LAT(LT), .idW(IW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .a_bus_i(a_bus), .b_bus_i(b_bus),
        .ack_o(ack), .div_a_o(div_a), .div_b_o(div_b), .div_ce_o(div_ce), .div_res_i(div_res),
        .res_o(res), .res_id_o(res_id), .res_valid_o(res_valid), .res_dz_o(res_dz),
        .inflight_o(inflight), .busy_o(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [NB-1:0] q15(logic [NB-1:0] a, logic [NB-1:0] b);
        logic signed [63:0] n, d, q;
        if (b == '0) return '0;
        n = $signed(a);
        d = $signed(b);
        n = n <<< 15;
        q = n / d;
        return q[NB-1:0];
    endfunction
    function automatic logic [NB-1:0] exp_res(logic [NB-1:0] a, logic [NB-1:0] b);
        if (b != '0) return q15(a, b);
        if (a == '0) return 32'h0000_0000;
        return a[NB-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction
    always @(posedge clk) begin
        dp[0] <= q15(div_a, div_b);
        for (int i = 1; i < LT; i++) dp[i] <= dp[i-1];
    end
    assign div_res = dp[LT-1];
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask
    task automatic set_op(input int idx, input logic [NB-1:0] a, input logic [NB-1:0] b);
        a_bus[idx*NB +: NB] = a;
        b_bus[idx*NB +: NB] = b;
    endtask
    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask
    always @(negedge clk) begin
        if (!rst_n) sb.delete();
        else begin
            chk("ack_ok", 64'(((ack & ~req) == '0) && $onehot0(ack)), 64'd1);
            if (ack != '0) begin
                g = 0;
                for (int i = 0; i < NR; i++) if (ack[i]) g = i;
                sb.push_back('{IW'(g), exp_res(a_bus[g*NB +: NB], b_bus[g*NB +: NB]),
                               b_bus[g*NB +: NB] == '0, cyc + 1});
            end
            if (res_valid) begin
                if (sb.size() == 0) chk("res_unexpected", 64'd1, 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("res_id", 64'(res_id), 64'(e.id));
                    chk("res", 64'(res), 64'(e.r));
                    chk("res_dz", 64'(res_dz), 64'(e.dz));
                    chk("latency", 64'(cyc - e.cyc), 64'(LT + 1));
                end
            end
        end
    end
    initial begin
        int peak, viol, r3_at;
        logic r3_done, prev0;
        logic [NB-1:0] da, db, a0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_div_ce", 64'(div_ce), 64'd0);
        chk("rst_div_a", 64'(div_a), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        // single op on requester 2
        set_op(2, 32'd6, 32'd3);
        @(posedge clk); #1 req = 4'b0100;
        @(negedge clk);
        chk("single_ack", 64'(ack), 64'h4);
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        chk("single_inflight1", 64'(inflight), 64'd1);
        chk("single_busy", 64'(busy), 64'd1);
        repeat (5) @(negedge clk);
        chk("single_valid", 64'(res_valid), 64'd1);
        chk("single_res", 64'(res), 64'h0001_0000);
        chk("single_id", 64'(res_id), 64'd2);
        chk("single_inflight0", 64'(inflight), 64'd0);
        repeat (4) @(negedge clk);
        // all four requesting from ptr=0
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, 32'(i + 1), 32'd1);
        peak = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1 req = 4'hF;
            @(negedge clk);
            chk("rot_ack", 64'(ack), 64'(1 << (k % NR)));
            if (int'(inflight) > peak) peak = int'(inflight);
        end
        @(posedge clk); #1 req = '0;
        repeat (8) begin
            @(negedge clk);
            if (int'(inflight) > peak) peak = int'(inflight);
        end
        chk("rot_peak", 64'(peak), 64'(LT + 1));
        // divide-by-zero on requester 1
        set_op(1, 32'd5, 32'd0);
        @(posedge clk); #1 req = 4'b0010;
        @(negedge clk); chk("dz_ack0", 64'(ack), 64'h2);
        @(posedge clk); #1 set_op(1, 32'hFFFF_FFFB, 32'd0);
        @(negedge clk); chk("dz_ack1", 64'(ack), 64'h2);
        @(posedge clk); #1 set_op(1, 32'd0, 32'd0);
        @(negedge clk); chk("dz_ack2", 64'(ack), 64'h2);
        @(posedge clk); #1 req = '0;
        repeat (8) @(negedge clk);
        // fairness between a hogging requester 0 and a late requester 3
        set_op(3, 32'hFFFF_FFF9, 32'd3);
        a0 = 32'd10;
        set_op(0, a0, 32'd2);
        r3_done = 1'b0; prev0 = 1'b0; viol = 0; r3_at = 99;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (prev0) a0 = a0 + 1;
            set_op(0, a0, 32'd2);
            req = {(c >= 2) && !r3_done, 2'b00, 1'b1};
            @(negedge clk);
            if (ack[0] && prev0 && req[3]) viol++;
            prev0 = ack[0];
            if (ack[3]) begin r3_done = 1'b1; r3_at = c; end
        end
        @(posedge clk); #1 req = '0;
        chk("fair_grant", 64'(r3_done && (r3_at - 2) < 4), 64'd1);
        chk("fair_rr", 64'(viol), 64'd0);
        repeat (8) @(negedge clk);
        // reset while three ops are in flight
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 set_op(1, 32'(i + 7), 32'd1); req = 4'b0010;
        end
        @(posedge clk); #1 req = '0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_inflight", 64'(inflight), 64'd0);
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        set_op(1, 32'd9, 32'd2);
        set_op(3, 32'd4, 32'd1);
        @(posedge clk); #1 req = 4'b1010;
        @(negedge clk); chk("mid_rst_ptr", 64'(ack), 64'h2);
        @(posedge clk); #1 req = 4'b1000;
        @(negedge clk); chk("mid_rst_next", 64'(ack), 64'h8);
        @(posedge clk); #1 req = '0;
        repeat (12) @(negedge clk);
        // idle hold
        da = div_a; db = div_b;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_ack", 64'(ack), 64'd0);
            chk("idle_valid", 64'(res_valid), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_ce", 64'(div_ce), 64'd1);
            chk("idle_div_a", 64'(div_a), 64'(da));
            chk("idle_div_b", 64'(div_b), 64'(db));
        end
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
